// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: RAM status codes, arbiter states
// and the default datapath width.
package cache_mem_arbiter_pkg;

  localparam int WORD_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_sat.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int MAX = 4,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == W'(MAX));
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache has priority unless
// icache has waited through STARVE_LIMIT consecutive dcache grants.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int WORD_W       = WORD_W_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t state_q;
  arb_state_t state_d;
  ramstate_t  ram_st;
  logic       d_req;
  logic       i_done;
  logic       d_done;
  logic       starve_at_max;
  logic [CNT_W-1:0] starve_cnt;

  assign ram_st = ramstate_t'(ramstate);
  assign d_req  = dREN | dWEN;
  assign i_done = (state_q == IGRANT) && iREN  && (ram_st == ACCESS);
  assign d_done = (state_q == DGRANT) && d_req && (ram_st == ACCESS);

  // Counts dcache wins while icache is kept waiting; any gap in iREN resets it.
  sat_counter #(.MAX(STARVE_LIMIT)) u_starve (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (d_done && iREN),
    .clr    (i_done || !iREN),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state_q)
      IDLE: begin
        if (iREN && starve_at_max)
          state_d = IGRANT;
        else if (d_req)
          state_d = DGRANT;
        else if (iREN)
          state_d = IGRANT;
      end
      IGRANT: begin
        ramaddr = iaddr;
        iload   = ramload;
        ramREN  = iREN;
        if (!iREN || i_done)
          state_d = IDLE;
        if (i_done)
          iwait = 1'b0;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        // Write takes precedence when both strobes are requested.
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        if (!d_req || d_done)
          state_d = IDLE;
        if (d_done)
          dwait = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

endmodule
